controle_multiciclo: RTL and testbench

Multicycle sequencer for the MIPS datapath: a Moore state machine that walks each instruction through fetch, decode, execute, memory and write-back steps. It drives the step counter `cont` and the 4-bit `aluop` consumed by the ALU, plus the register-file, memory and PC strobes. The ALU evaluates only when `cont == 6`, so the step encoding here is normative. It sits between the instruction register (opcode/funct) and the ALU, register file and memory.

---
 rtl/mips_pkg.sv | 40 ++++
 rtl/controle_alu.sv | 26 ++
 rtl/controle_multiciclo.sv | 164 ++++++++++++++++
 tb/tb_controle_multiciclo.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the multicycle MIPS control path.
//   state_t  : sequencer step codes; the numeric value is what appears on cont
//   OP_*     : instruction opcodes (IR[31:26]) recognised by the sequencer
//   FN_*     : R-type function codes (IR[5:0]) recognised by the ALU decoder
//   ALU_*    : aluop encodings understood by the ALU
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_BAD = 4'd15;

endpackage

// File: rtl/controle_alu.sv
// controle_alu: combinational R-type function decoder.
//   funct : IR[5:0]
//   aluop : ALU operation for the function code, ALU_BAD when unknown
//   valid : 1 when funct is a supported R-type function
module controle_alu
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] aluop,
  output logic       valid
);

  always_comb begin
    aluop = ALU_BAD;
    valid = 1'b0;
    case (funct)
      FN_ADD: begin aluop = ALU_ADD; valid = 1'b1; end
      FN_SUB: begin aluop = ALU_SUB; valid = 1'b1; end
      FN_AND: begin aluop = ALU_AND; valid = 1'b1; end
      FN_OR:  begin aluop = ALU_OR;  valid = 1'b1; end
      FN_SLT: begin aluop = ALU_SLT; valid = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// controle_multiciclo: Moore sequencer for the multicycle MIPS datapath.
//   clk, reset    : clock, asynchronous active-high reset
//   run           : start enable, only looked at in FETCH
//   opcode, funct : instruction fields from the IR
//   cont          : current step code (the ALU evaluates when cont == 6)
//   aluop         : ALU operation
//   pc_write .. alu_src_a, alu_src_b, pc_source : datapath strobes/selects
//   ilegal        : pulse on unknown opcode (DECODE) or funct (EXECUTE)
//   instr_count   : retired-instruction counter, wraps
module controle_multiciclo
  import mips_pkg::*;
#(
  parameter int CONT_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  output logic [CONT_W-1:0] cont,
  output logic [3:0]        aluop,
  output logic              pc_write,
  output logic              pc_write_cond,
  output logic              iord,
  output logic              mem_read,
  output logic              mem_write,
  output logic              ir_write,
  output logic              reg_write,
  output logic              reg_dst,
  output logic              mem_to_reg,
  output logic              alu_src_a,
  output logic [1:0]        alu_src_b,
  output logic [1:0]        pc_source,
  output logic              ilegal,
  output logic [CNT_W-1:0]  instr_count
);

  state_t     state;
  state_t     next_state;
  logic [3:0] fn_aluop;
  logic       fn_valid;
  logic       retire;
  logic       fetch_go;

  controle_alu u_alu (
    .funct (funct),
    .aluop (fn_aluop),
    .valid (fn_valid)
  );

  assign cont = CONT_W'(state);

  // Every terminal step returns to FETCH, so being in one means an
  // instruction retires on this edge. Illegal aborts leave from DECODE or
  // EXECUTE and are therefore never counted.
  assign retire = (state == S_MEMWB) || (state == S_MEMWRITE) ||
                  (state == S_ALUWB) || (state == S_BRANCH) ||
                  (state == S_JUMP);

  // The reset term keeps the fetch strobes quiet while reset is held.
  assign fetch_go = run && !reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else begin
      state <= next_state;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = run ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_R:         next_state = S_EXECUTE;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_FETCH;
        endcase
      end
      S_MEMADR:   next_state = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTE:  next_state = fn_valid ? S_ALUWB : S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  always_comb begin
    aluop         = ALU_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    ilegal        = 1'b0;
    case (state)
      S_FETCH: begin
        if (fetch_go) begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'd1;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: ;
          default: ilegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEMREAD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        aluop     = fn_aluop;
        ilegal    = !fn_valid;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// tb_controle_multiciclo: self-checking bench for controle_multiciclo.
module tb_controle_multiciclo;

  typedef struct packed {
    logic [3:0] cont;
    logic [3:0] aluop;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       ilegal;
  } outs_t;

  // seq holds the expected step codes, nibble k = step k of the instruction
  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [2:0]  n;
    logic [19:0] seq;
    logic        counted;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [3:0]  cont;
  logic [3:0]  aluop;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic        ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, ilegal;
  logic [1:0]  alu_src_b, pc_source;
  logic [31:0] instr_count;

  outs_t act_o;
  outs_t q[$];
  vec_t  vecs[10];
  int    total = 0;
  int    bad   = 0;
  logic [31:0] exp_cnt;

  controle_multiciclo #(.CONT_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct),
    .cont(cont), .aluop(aluop), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .pc_source(pc_source), .ilegal(ilegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  assign act_o = {cont, aluop, pc_write, pc_write_cond, iord, mem_read,
                  mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, pc_source, ilegal};

  // Reference outputs for a step, written from the step descriptions.
  function automatic outs_t model(input logic [3:0] c, input logic [5:0] op,
                                  input logic [5:0] fn, input logic go);
    outs_t o;
    o = '0;
    o.cont  = c;
    o.aluop = 4'd2;
    case (c)
      4'd0: if (go) begin
        o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1;
        o.alu_src_b = 2'd1;
      end
      4'd1: begin
        o.alu_src_b = 2'd3;
        o.ilegal = !(op == 6'h00 || op == 6'h23 || op == 6'h2B ||
                     op == 6'h04 || op == 6'h02);
      end
      4'd2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
      4'd3: begin o.iord = 1'b1; o.mem_read = 1'b1; end
      4'd4: begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
      4'd5: begin o.iord = 1'b1; o.mem_write = 1'b1; end
      4'd6: begin
        o.alu_src_a = 1'b1;
        case (fn)
          6'h20: o.aluop = 4'd2;
          6'h22: o.aluop = 4'd6;
          6'h24: o.aluop = 4'd0;
          6'h25: o.aluop = 4'd1;
          6'h2A: o.aluop = 4'd7;
          default: begin o.aluop = 4'd15; o.ilegal = 1'b1; end
        endcase
      end
      4'd7: begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
      4'd8: begin
        o.alu_src_a = 1'b1; o.aluop = 4'd6; o.pc_write_cond = 1'b1;
        o.pc_source = 2'd1;
      end
      4'd9: begin o.pc_write = 1'b1; o.pc_source = 2'd2; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pushes the expected per-step outputs, then pops one per cycle as the
  // DUT produces it; returns with the DUT back in FETCH, #1 after the edge.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int n, input logic [19:0] seq);
    outs_t e;
    opcode = op;
    funct  = fn;
    for (int k = 0; k < n; k++) q.push_back(model(seq[4*k +: 4], op, fn, 1'b1));
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      e = q.pop_front();
      check($sformatf("step%0d op=%h fn=%h", k, op, fn), 32'(act_o), 32'(e));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{6'h00, 6'h22, 3'd4, 20'h07610, 1'b1};  // sub
    vecs[1] = '{6'h00, 6'h20, 3'd4, 20'h07610, 1'b1};  // add
    vecs[2] = '{6'h00, 6'h24, 3'd4, 20'h07610, 1'b1};  // and
    vecs[3] = '{6'h00, 6'h25, 3'd4, 20'h07610, 1'b1};  // or
    vecs[4] = '{6'h23, 6'h00, 3'd5, 20'h43210, 1'b1};  // lw
    vecs[5] = '{6'h2B, 6'h00, 3'd4, 20'h05210, 1'b1};  // sw
    vecs[6] = '{6'h04, 6'h00, 3'd3, 20'h00810, 1'b1};  // beq
    vecs[7] = '{6'h02, 6'h00, 3'd3, 20'h00910, 1'b1};  // j
    vecs[8] = '{6'h3F, 6'h00, 3'd2, 20'h00010, 1'b0};  // illegal opcode
    vecs[9] = '{6'h00, 6'h00, 3'd3, 20'h00610, 1'b0};  // illegal funct

    reset = 1'b1; run = 1'b0; opcode = 6'h00; funct = 6'h00;
    exp_cnt = 32'd0;
    #12;
    check("reset outputs", 32'(act_o), 32'(model(4'd0, 6'h00, 6'h00, 1'b0)));
    check("reset count", instr_count, 32'd0);
    run = 1'b1;
    #1;
    check("no strobe in reset", 32'(act_o), 32'(model(4'd0, 6'h00, 6'h00, 1'b0)));
    run = 1'b0;

    // Park in FETCH with run low for five cycles.
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("park%0d", i), 32'(act_o), 32'(model(4'd0, 6'h00, 6'h00, 1'b0)));
      @(posedge clk);
      #1;
    end
    run = 1'b1;
    #1;
    check("fetch same cycle", 32'(act_o), 32'(model(4'd0, 6'h00, 6'h00, 1'b1)));

    for (int v = 0; v < 10; v++) begin
      run_instr(vecs[v].op, vecs[v].fn, int'(vecs[v].n), vecs[v].seq);
      if (vecs[v].counted) exp_cnt = exp_cnt + 32'd1;
      check($sformatf("count after vec%0d", v), instr_count, exp_cnt);
    end

    // run dropped during DECODE: the instruction still completes, then parks.
    opcode = 6'h00; funct = 6'h2A;
    @(posedge clk); #1;
    run = 1'b0;
    check("slt decode", 32'(cont), 32'd1);
    @(posedge clk); #1;
    check("slt execute", 32'(act_o), 32'(model(4'd6, 6'h00, 6'h2A, 1'b1)));
    @(posedge clk); #1;
    check("slt aluwb", 32'(cont), 32'd7);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 32'd1;
    check("slt count", instr_count, exp_cnt);
    @(posedge clk); #1;
    check("parked after run drop", 32'(act_o), 32'(model(4'd0, 6'h00, 6'h2A, 1'b0)));
    check("parked count", instr_count, exp_cnt);
    run = 1'b1;

    // Reset while lw sits in MEMREAD.
    opcode = 6'h23; funct = 6'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    check("lw at memread", 32'(cont), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async reset outputs", 32'(act_o), 32'(model(4'd0, 6'h23, 6'h00, 1'b0)));
    check("async reset count", instr_count, 32'd0);
    @(posedge clk); #1;
    check("held reset reg_write", 32'(reg_write), 32'd0);
    check("held reset cont", 32'(cont), 32'd0);
    reset = 1'b0;
    #1;
    check("release fetch", 32'(act_o), 32'(model(4'd0, 6'h23, 6'h00, 1'b1)));
    run_instr(6'h23, 6'h00, 5, 20'h43210);
    check("lw after reset count", instr_count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
